vga_sprite_engine: RTL

Parametrised sprite compositor for the VGA pipeline. It generalises the fixed three-sprite logic to NUM_SPRITES sprites. Each sprite has a horizontal and vertical window, per-pixel horizontal scaling, mirroring, a per-sprite enable, and a per-sprite 3-colour palette. The block sits between the timing generator, which supplies the counters and active flags, and the final colour mux. It outputs one registered sprite pixel per clock and a latched pairwise collision vector.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_sprite_unit.sv | 141 ++++++++++++++
 rtl/vga_sprite_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the sprite compositor: config field codes, sprite FSM
// states and the pair-to-bit mapping of the collision vector.
package vga_pkg;

  localparam logic [2:0] FIELD_XSTART = 3'd0;
  localparam logic [2:0] FIELD_YSTART = 3'd1;
  localparam logic [2:0] FIELD_PIXELS = 3'd2;
  localparam logic [2:0] FIELD_CTRL   = 3'd3;
  localparam logic [2:0] FIELD_COLOR1 = 3'd4;
  localparam logic [2:0] FIELD_COLOR2 = 3'd5;
  localparam logic [2:0] FIELD_COLOR3 = 3'd6;

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} sprite_state_t;

  // Lexicographic position of pair (i,j), i<j, among n sprites.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/vga_sprite_unit.sv
// One sprite: config registers, row shadow registers and the row-drawing FSM.
// color_idx is the index that the top level registers onto the output next edge.
//   state | meaning
//   IDLE  | waiting for h_counter==x_start inside the vertical window
//   DRAW  | walking the latched row, each pixel held max(scale,1) cycles
module vga_sprite_unit
  import vga_pkg::*;
#(
  parameter int SPRITE_PIXELS = 16,
  parameter int CNT_W         = 10,
  parameter int COLOR_W       = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   h_counter,
  input  logic [CNT_W-1:0]   v_counter,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_field,
  input  logic [31:0]        cfg_data,
  output logic [1:0]         color_idx,
  output logic [COLOR_W-1:0] color1,
  output logic [COLOR_W-1:0] color2,
  output logic [COLOR_W-1:0] color3
);

  localparam int PIX_W = 2 * SPRITE_PIXELS;
  localparam int IDX_W = $clog2(SPRITE_PIXELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_PIXELS - 1);

  logic [CNT_W-1:0] x_start, y_start, height;
  logic [PIX_W-1:0] pixels, sh_pixels;
  logic [5:0]       scale, sh_scale, cnt, cnt_n;
  logic             enable, mirror, sh_mirror;
  logic [IDX_W-1:0] idx, idx_n;
  sprite_state_t    state, state_n;

  logic             trigger;
  logic [CNT_W:0]   y_end;
  logic [5:0]       scale_eff, sh_scale_eff;
  logic [IDX_W-1:0] start_idx, end_idx;
  logic             unused_cfg_bits;

  function automatic logic [1:0] pix_at(input logic [PIX_W-1:0] vec, input logic [IDX_W-1:0] i);
    return vec[{i, 1'b0} +: 2];
  endfunction

  assign unused_cfg_bits = ^cfg_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_start <= '0;
      y_start <= '0;
      height  <= '0;
      pixels  <= '0;
      scale   <= '0;
      enable  <= 1'b0;
      mirror  <= 1'b0;
      color1  <= '0;
      color2  <= '0;
      color3  <= '0;
    end else if (cfg_we) begin
      case (cfg_field)
        FIELD_XSTART: x_start <= cfg_data[CNT_W-1:0];
        FIELD_YSTART: begin
          y_start <= cfg_data[CNT_W-1:0];
          height  <= cfg_data[CNT_W+15:16];
        end
        FIELD_PIXELS: pixels <= cfg_data[PIX_W-1:0];
        FIELD_CTRL: begin
          scale  <= cfg_data[5:0];
          enable <= cfg_data[8];
          mirror <= cfg_data[9];
        end
        FIELD_COLOR1: color1 <= cfg_data[COLOR_W-1:0];
        FIELD_COLOR2: color2 <= cfg_data[COLOR_W-1:0];
        FIELD_COLOR3: color3 <= cfg_data[COLOR_W-1:0];
        default: ;
      endcase
    end
  end

  // Window end kept one bit wider so y_start+height never wraps.
  assign y_end        = {1'b0, y_start} + {1'b0, height};
  assign trigger      = enable && (h_counter == x_start) && (v_counter >= y_start)
                        && ({1'b0, v_counter} < y_end);
  assign scale_eff    = (scale == 6'd0) ? 6'd1 : scale;
  assign sh_scale_eff = (sh_scale == 6'd0) ? 6'd1 : sh_scale;
  assign start_idx    = mirror ? LAST_IDX : '0;
  assign end_idx      = sh_mirror ? '0 : LAST_IDX;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    color_idx = 2'd0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n   = DRAW;
          idx_n     = start_idx;
          cnt_n     = scale_eff - 6'd1;
          color_idx = pix_at(pixels, start_idx);
        end
      end
      DRAW: begin
        if (cnt != 6'd0) begin
          cnt_n     = cnt - 6'd1;
          color_idx = pix_at(sh_pixels, idx);
        end else if (idx == end_idx) begin
          state_n = IDLE;
        end else begin
          idx_n     = sh_mirror ? idx - 1'b1 : idx + 1'b1;
          cnt_n     = sh_scale_eff - 6'd1;
          color_idx = pix_at(sh_pixels, idx_n);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      sh_pixels <= '0;
      sh_scale  <= '0;
      sh_mirror <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (state == IDLE && trigger) begin
        sh_pixels <= pixels;
        sh_scale  <= scale;
        sh_mirror <= mirror;
      end
    end
  end

endmodule

// File: rtl/vga_sprite_engine.sv
// Sprite compositor: NUM_SPRITES sprite units, lowest-index-wins priority mux,
// sticky pairwise collision flags and the registered pixel outputs.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter  int NUM_SPRITES   = 4,
  parameter  int SPRITE_PIXELS = 16,
  parameter  int CNT_W         = 10,
  parameter  int COLOR_W       = 12,
  localparam int SEL_W         = $clog2(NUM_SPRITES),
  localparam int NUM_PAIRS     = NUM_SPRITES * (NUM_SPRITES - 1) / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     h_counter,
  input  logic [CNT_W-1:0]     v_counter,
  input  logic                 h_active,
  input  logic                 v_active,
  input  logic                 cfg_we,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [2:0]           cfg_field,
  input  logic [31:0]          cfg_data,
  input  logic                 coll_clear,
  output logic                 pix_valid,
  output logic                 pix_hit,
  output logic [COLOR_W-1:0]   pix_color,
  output logic [NUM_PAIRS-1:0] collision_bits
);

  logic [1:0]         color_idx [NUM_SPRITES];
  logic [COLOR_W-1:0] palette   [NUM_SPRITES][3];
  logic               hit_c;
  logic [COLOR_W-1:0] color_c;
  logic [NUM_PAIRS-1:0] coll_now;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unit
    vga_sprite_unit #(
      .SPRITE_PIXELS(SPRITE_PIXELS),
      .CNT_W        (CNT_W),
      .COLOR_W      (COLOR_W)
    ) u_unit (
      .clk      (clk),
      .reset    (reset),
      .h_counter(h_counter),
      .v_counter(v_counter),
      .cfg_we   (cfg_we && (cfg_sel == SEL_W'(g))),
      .cfg_field(cfg_field),
      .cfg_data (cfg_data),
      .color_idx(color_idx[g]),
      .color1   (palette[g][0]),
      .color2   (palette[g][1]),
      .color3   (palette[g][2])
    );
  end

  // Scan from the highest index down so the lowest opaque sprite is written last.
  always_comb begin
    hit_c   = 1'b0;
    color_c = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (color_idx[i] != 2'd0) begin
        hit_c = 1'b1;
        case (color_idx[i])
          2'd1:    color_c = palette[i][0];
          2'd2:    color_c = palette[i][1];
          default: color_c = palette[i][2];
        endcase
      end
    end
  end

  always_comb begin
    coll_now = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      for (int j = i + 1; j < NUM_SPRITES; j++) begin
        coll_now[pair_index(i, j, NUM_SPRITES)] = h_active && v_active
            && (color_idx[i] != 2'd0) && (color_idx[j] != 2'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid      <= 1'b0;
      pix_hit        <= 1'b0;
      pix_color      <= '0;
      collision_bits <= '0;
    end else begin
      pix_valid      <= h_active && v_active;
      pix_hit        <= hit_c;
      pix_color      <= color_c;
      collision_bits <= (coll_clear ? '0 : collision_bits) | coll_now;
    end
  end

endmodule
